mips_pc_sequencer: RTL and testbench
====================================

// Module: mips_pc_sequencer
// PURPOSE
//  Fetch-side program-counter sequencer for mips_cpu_harvard. Drives instr_address to
//  instruction memory and applies MIPS branch/jump semantics, including the
//  one-instruction delay slot. Raises halt (active=0) when control reaches the halt
//  address. Decode feeds it resolved redirects. It sits directly upstream of the
//  decode/execute datapath.
// PARAMETERS
//  RESET_VECTOR  32'hBFC00000  first fetch address after reset
//  HALT_ADDRESS  32'h00000000  fetch address that ends execution
// PORTS
//  clk              in   1   rising-edge clock
//  reset            in   1   synchronous, active-high reset
//  clk_enable       in   1   global advance enable; 0 freezes all state
//  stall            in   1   datapath hold (multi-cycle op); 0 = advance allowed
//  redirect_valid   in   1   instr at instr_address is a taken branch/jump
//  redirect_target  in   32  destination of that branch/jump
//  instr_address    out  32  current fetch PC
//  link_address     out  32  instr_address+8 (JAL/JALR/BxxAL link value), combinational
//  in_delay_slot    out  1   current instr is a delay slot
//  active           out  1   1 while executing; 0 once halted
//  addr_error       out  1   sticky: misaligned redirect target seen
// BEHAVIOUR
//  - Reset (sync, highest priority, ignores clk_enable):
//    instr_address=RESET_VECTOR, state=RUN, pending=0, active=1, in_delay_slot=0,
//    addr_error=0.
//  - Advance condition adv = clk_enable & ~stall & (state!=HALTED). No adv: all
//    registers hold.
//  - States:
//    RUN     adv & ~redirect_valid: PC<=PC+4.
//            adv & redirect_valid: pending<=redirect_target; PC<=PC+4; ->DELAY.
//    DELAY   in_delay_slot=1. adv:
//            * if pending[1:0]!=0: addr_error<=1, PC holds, ->HALTED.
//            * else PC<=pending, ->RUN.
//            redirect_valid in DELAY (branch in delay slot) is ignored.
//    HALTED  active=0, PC frozen, all inputs ignored until reset.
//  - Halt detection: any transition that loads PC==HALT_ADDRESS (redirect or
//    sequential) goes to HALTED instead of RUN.
//    * Same edge: instr_address=HALT_ADDRESS and active=0.
//    * The datapath samples register_v0 while instr_address==HALT_ADDRESS.
//  - PC arithmetic: 32-bit modulo 2^32. 32'hFFFFFFFC+4 = 0, which halts when
//    HALT_ADDRESS=0.
//  - Latency:
//    * Redirect observed at edge N is applied to fetch at edge N+2.
//    * The delay slot is fetched at edge N+1.
//  - Stall or clk_enable low while in DELAY keeps pending and DELAY state intact.
//  - Reset mid-DELAY discards pending; the next fetch is RESET_VECTOR.
//  - in_delay_slot and active are registered outputs; link_address is pure
//    combinational.
// TESTING
//  1. Reset, no redirects, 4 cycles -> instr_address BFC00000, BFC00004, BFC00008,
//     BFC0000C; active=1 throughout.
//  2. redirect_valid=1, target=BFC0000C at PC BFC00000 -> BFC00004 (in_delay_slot=1),
//     then BFC0000C; BFC00008 never fetched.
//  3. jr-style redirect to 0 at BFC00010:
//     * BFC00014 fetched as the delay slot.
//     * Next edge: instr_address=0, active=0.
//     * Further edges and redirects leave it unchanged.
//  4. stall=1 for 3 cycles in DELAY (target BFC00100) -> PC holds BFC00004, then
//     BFC00100 on first non-stall edge; clk_enable=0 gives identical holding.
//  5. Misaligned target BFC00102 -> delay slot runs, then addr_error=1, active=0,
//     PC stays at slot address.
//  6. Reset asserted while in DELAY -> next edge PC=BFC00000, in_delay_slot=0,
//     pending target never fetched.
//  7. link_address check: at PC BFC00010, link_address=BFC00018.

Source files
------------

// File: rtl/mips_pc_sequencer.sv
// Fetch-side program counter with MIPS branch delay slot, halt detection and a sticky
// misaligned-target error flag.
module mips_pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_address,
  output logic [31:0] link_address,
  output logic        in_delay_slot,
  output logic        active,
  output logic        addr_error
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] pending, pending_next;
  logic        addr_error_next;
  logic        adv;
  logic [31:0] pc_plus4;

  assign adv      = clk_enable & ~stall & (state != HALTED);
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    // NOTE: every output of this block gets a hold value first, so no path can infer a latch.
    state_next      = state;
    pc_next         = pc;
    pending_next    = pending;
    addr_error_next = addr_error;
    if (adv) begin
      case (state)
        RUN: begin
          pc_next = pc_plus4;
          if (redirect_valid) pending_next = redirect_target;
          // Falling onto the halt address wins over entering the delay slot.
          if (pc_plus4 == HALT_ADDRESS) state_next = HALTED;
          else if (redirect_valid)      state_next = DELAY;
          else                          state_next = RUN;
        end
        DELAY: begin
          // A branch sitting in the delay slot is architecturally ignored.
          if (pending[1:0] != 2'b00) begin
            addr_error_next = 1'b1;
            state_next      = HALTED;
          end else begin
            pc_next    = pending;
            state_next = (pending == HALT_ADDRESS) ? HALTED : RUN;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state      <= RUN;
      pc         <= RESET_VECTOR;
      pending    <= 32'd0;
      addr_error <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      pending    <= pending_next;
      addr_error <= addr_error_next;
    end
  end

  // Status outputs are straight decodes of the state flops, so they change only on the edge.
  assign instr_address = pc;
  assign link_address  = pc + 32'd8;
  assign in_delay_slot = (state == DELAY);
  assign active        = (state != HALTED);

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Scoreboard bench for mips_pc_sequencer: directed scenarios plus random traffic checked
// against a queue-based reference model of fetch behaviour.
module tb_mips_pc_sequencer;

  localparam logic [31:0] RV   = 32'hBFC00000;
  localparam logic [31:0] HALT = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic [31:0] instr_address;
  logic [31:0] link_address;
  logic        in_delay_slot;
  logic        active;
  logic        addr_error;

  mips_pc_sequencer #(.RESET_VECTOR(RV), .HALT_ADDRESS(HALT)) dut (
    .clk             (clk),
    .reset           (reset),
    .clk_enable      (clk_enable),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_address   (instr_address),
    .link_address    (link_address),
    .in_delay_slot   (in_delay_slot),
    .active          (active),
    .addr_error      (addr_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] link;
    logic        slot;
    logic        act;
    logic        err;
  } expect_t;

  expect_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: fetch PC, a queue holding the branch target still owed after the slot.
  logic [31:0] m_pc = RV;
  logic [31:0] m_owed[$];
  bit          m_halted = 0;
  bit          m_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit ce, input bit st, input bit rv,
                      input logic [31:0] tgt);
    expect_t e;
    logic [31:0] t;
    @(negedge clk);
    reset = rst; clk_enable = ce; stall = st; redirect_valid = rv; redirect_target = tgt;
    if (rst) begin
      m_pc = RV; m_owed.delete(); m_halted = 0; m_err = 0;
    end else if (ce && !st && !m_halted) begin
      if (m_owed.size() != 0) begin
        t = m_owed.pop_front();
        if (t % 4 != 0) begin
          m_err = 1; m_halted = 1;
        end else begin
          m_pc = t;
          if (m_pc == HALT) m_halted = 1;
        end
      end else begin
        if (rv) m_owed.push_back(tgt);
        m_pc = m_pc + 32'd4;
        if (m_pc == HALT) begin
          m_halted = 1; m_owed.delete();
        end
      end
    end
    e.pc = m_pc; e.link = m_pc + 32'd8; e.slot = (m_owed.size() != 0);
    e.act = !m_halted; e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 32'd0);
  endtask

  // Monitor: the DUT presents a fresh output set after every edge; compare against the oldest
  // expectation once stimulus has queued one.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("instr_address", instr_address, e.pc);
        check("link_address",  link_address,  e.link);
        check("in_delay_slot", {31'd0, in_delay_slot}, {31'd0, e.slot});
        check("active",        {31'd0, active},        {31'd0, e.act});
        check("addr_error",    {31'd0, addr_error},    {31'd0, e.err});
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    int r;
    // Plain sequential fetch from reset.
    step(1, 0, 0, 0, 32'd0);
    idle(3);
    // Taken branch skipping BFC00008.
    step(1, 1, 0, 0, 32'd0);
    step(0, 1, 0, 1, 32'hBFC0000C);
    idle(2);
    // Jump to the halt address, then further activity is ignored.
    step(1, 1, 0, 0, 32'd0);
    idle(4);
    step(0, 1, 0, 1, 32'h00000000);
    idle(1);
    step(0, 1, 0, 1, 32'hBFC00040);
    idle(2);
    // Stall, then clock-enable low, while in the delay slot.
    step(1, 1, 0, 0, 32'd0);
    step(0, 1, 0, 1, 32'hBFC00100);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 32'hBFC00300);
    idle(1);
    step(1, 1, 0, 0, 32'd0);
    step(0, 1, 0, 1, 32'hBFC00100);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'hBFC00300);
    idle(1);
    // Misaligned target.
    step(1, 1, 0, 0, 32'd0);
    step(0, 1, 0, 1, 32'hBFC00102);
    idle(3);
    // Reset during the delay slot.
    step(1, 1, 0, 0, 32'd0);
    step(0, 1, 0, 1, 32'hBFC00200);
    step(1, 1, 0, 0, 32'd0);
    idle(2);
    // Sequential wrap from FFFFFFFC to the halt address.
    step(1, 1, 0, 0, 32'd0);
    step(0, 1, 0, 1, 32'hFFFFFFFC);
    idle(3);
    // Random traffic.
    step(1, 1, 0, 0, 32'd0);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 31);
      if (r == 0)      tgt = 32'h00000000;
      else if (r == 1) tgt = RV + ($urandom & 32'hFFF);
      else if (r == 2) tgt = 32'hFFFFFFF8;
      else             tgt = RV + ($urandom & 32'hFFC);
      step(($urandom_range(0, 49) == 0) || (m_halted && $urandom_range(0, 4) == 0),
           $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, tgt);
    end
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
